lpddr_cmd_sched: RTL and testbench

//  Command scheduler between the OR1K memory front-end and the mobile-DDR PHY pins (CK/CKE/CS/RAS/CAS/WE/A/BA).

---
 rtl/lpddr_pkg.sv | 34 +++
 rtl/lpddr_ref_timer.sv | 59 +++++
 rtl/lpddr_cmd_sched.sv | 188 ++++++++++++++++++
 tb/tb_lpddr_cmd_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr_pkg.sv
// Shared definitions for the mobile-DDR command scheduler: command encodings,
// scheduler states and address/counter widths.
package lpddr_pkg;

  localparam int BA_W   = 2;
  localparam int ADDR_W = 14;
  localparam int CNT_W  = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [ADDR_W-1:0] ADDR_A10_ALL = 14'h0400;
  localparam logic [BA_W-1:0]   BA_EMR       = 2'b10;

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_PREA,  S_W_RP,   S_REF1,
    S_W_RFC1,    S_REF2,  S_W_RFC2, S_MRS,
    S_W_MRD1,    S_EMRS,  S_W_MRD2, S_IDLE,
    S_R_PREA,    S_R_W_RP, S_R_REF, S_R_W_RFC
  } sched_state_e;

  // Host commands that are forwarded to the pins; anything else becomes a NOP.
  function automatic logic host_cmd_issuable(input logic [3:0] cmd);
    return (cmd == CMD_ACT) || (cmd == CMD_RD) || (cmd == CMD_WR) || (cmd == CMD_PRE);
  endfunction

endpackage

// File: rtl/lpddr_ref_timer.sv
// Refresh interval timer: free-running once enabled, raises a pending flag on
// each expiry and a sticky overrun flag if the previous refresh is still owed.
module lpddr_ref_timer
  import lpddr_pkg::*;
#(
  parameter int T_REFI_CYC = 390
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ref_issue,
  output logic ref_pending,
  output logic ref_overrun
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(T_REFI_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             expire;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    expire    = 1'b0;
    if (!enable) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      cnt_d  = RELOAD;
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (ref_issue) pending_d = 1'b0;
    // A refresh issuing in the expiry cycle retires the old request, so no overrun.
    if (expire) begin
      pending_d = 1'b1;
      if (pending_q && !ref_issue) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign ref_pending = pending_q;
  assign ref_overrun = overrun_q;

endmodule

// File: rtl/lpddr_cmd_sched.sv
// Mobile-DDR command scheduler: power-up init, then host commands vs. auto-refresh.
// Optional statistics counters are enabled with the LPDDR_SCHED_STATS_EN macro.
module lpddr_cmd_sched
  import lpddr_pkg::*;
#(
  parameter int          T_INIT_CYC = 10000,
  parameter int          T_REFI_CYC = 390,
  parameter int          T_RP_CYC   = 2,
  parameter int          T_RFC_CYC  = 5,
  parameter int          T_MRD_CYC  = 2,
  parameter logic [13:0] MR_VAL     = 14'h0032,
  parameter logic [13:0] EMR_VAL    = 14'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [3:0]  host_cmd,
  input  logic [1:0]  host_ba,
  input  logic [13:0] host_addr,
  output logic        ram_cke,
  output logic [3:0]  ram_cmd_n,
  output logic [1:0]  ram_ba,
  output logic [13:0] ram_addr,
  output logic        init_done,
  output logic        ref_overrun
`ifdef LPDDR_SCHED_STATS_EN
  ,
  output logic [15:0] ref_count,
  output logic [15:0] host_stall_cyc
`endif
);

  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(T_INIT_CYC - 1);
  localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(T_RP_CYC - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'(T_RFC_CYC - 1);
  localparam logic [CNT_W-1:0] MRD_LOAD  = CNT_W'(T_MRD_CYC - 1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cke_q, cke_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              init_done_q, init_done_d;
  logic              ref_pending;
  logic              cnt_zero;

  assign cnt_zero   = (cnt_q == '0);
  assign host_ready = (state_q == S_IDLE) && !ref_pending;

  lpddr_ref_timer #(.T_REFI_CYC(T_REFI_CYC)) u_ref_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (init_done_q),
    .ref_issue  (state_q == S_R_REF),
    .ref_pending(ref_pending),
    .ref_overrun(ref_overrun)
  );

  // Each state decides the command driven on the pins in the following cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cke_d       = cke_q;
    cmd_d       = cke_q ? CMD_NOP : CMD_DESEL;
    ba_d        = ba_q;
    addr_d      = addr_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_INIT_WAIT: begin
        if (cnt_zero) begin
          cke_d   = 1'b1;
          state_d = S_PREA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PREA, S_R_PREA: begin
        cmd_d   = CMD_PRE;
        addr_d  = ADDR_A10_ALL;
        cnt_d   = RP_LOAD;
        state_d = (state_q == S_PREA) ? S_W_RP : S_R_W_RP;
      end
      S_REF1, S_REF2, S_R_REF: begin
        cmd_d   = CMD_REF;
        cnt_d   = RFC_LOAD;
        state_d = (state_q == S_REF1) ? S_W_RFC1 :
                  (state_q == S_REF2) ? S_W_RFC2 : S_R_W_RFC;
      end
      S_MRS: begin
        cmd_d   = CMD_MRS;
        ba_d    = '0;
        addr_d  = MR_VAL;
        cnt_d   = MRD_LOAD;
        state_d = S_W_MRD1;
      end
      S_EMRS: begin
        cmd_d   = CMD_MRS;
        ba_d    = BA_EMR;
        addr_d  = EMR_VAL;
        cnt_d   = MRD_LOAD;
        state_d = S_W_MRD2;
      end
      S_W_RP, S_W_RFC1, S_W_RFC2, S_W_MRD1, S_W_MRD2, S_R_W_RP, S_R_W_RFC: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          unique case (state_q)
            S_W_RP:   state_d = S_REF1;
            S_W_RFC1: state_d = S_REF2;
            S_W_RFC2: state_d = S_MRS;
            S_W_MRD1: state_d = S_EMRS;
            S_R_W_RP: state_d = S_R_REF;
            S_W_MRD2: begin
              state_d     = S_IDLE;
              init_done_d = 1'b1;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_IDLE: begin
        if (ref_pending) begin
          state_d = S_R_PREA;
        end else if (host_valid && host_cmd_issuable(host_cmd)) begin
          cmd_d  = host_cmd;
          ba_d   = host_ba;
          addr_d = host_addr;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT_WAIT;
      cnt_q       <= INIT_LOAD;
      cke_q       <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= '0;
      addr_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cke_q       <= cke_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign ram_cke   = cke_q;
  assign ram_cmd_n = cmd_q;
  assign ram_ba    = ba_q;
  assign ram_addr  = addr_q;
  assign init_done = init_done_q;

`ifdef LPDDR_SCHED_STATS_EN
  logic [15:0] ref_count_q, ref_count_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    ref_count_d = ref_count_q;
    stall_d     = stall_q;
    if (state_q == S_R_REF) ref_count_d = ref_count_q + 16'd1;
    if (init_done_q && host_valid && !host_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_count_q <= '0;
      stall_q     <= '0;
    end else begin
      ref_count_q <= ref_count_d;
      stall_q     <= stall_d;
    end
  end

  assign ref_count      = ref_count_q;
  assign host_stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_lpddr_cmd_sched.sv
// Directed bench for lpddr_cmd_sched with short timing parameters; a second
// instance with a 3-cycle refresh interval exercises the sticky overrun flag.
module tb_lpddr_cmd_sched;

  logic        clk;
  logic        rst;
  logic        host_valid;
  logic        host_ready;
  logic [3:0]  host_cmd;
  logic [1:0]  host_ba;
  logic [13:0] host_addr;
  logic        ram_cke;
  logic [3:0]  ram_cmd_n;
  logic [1:0]  ram_ba;
  logic [13:0] ram_addr;
  logic        init_done;
  logic        ref_overrun;

  logic        ovr_ready, ovr_cke, ovr_init_done, ovr_overrun;
  logic [3:0]  ovr_cmd_n;
  logic [1:0]  ovr_ba;
  logic [13:0] ovr_addr;

`ifdef LPDDR_SCHED_STATS_EN
  logic [15:0] ref_count, host_stall_cyc, ovr_ref_count, ovr_stall;
`endif

  int checks;
  int errors;
  int cyc;
  logic [3:0] initSeq [21];

  lpddr_cmd_sched #(
    .T_INIT_CYC(20), .T_REFI_CYC(40), .T_RP_CYC(2), .T_RFC_CYC(5), .T_MRD_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_cmd(host_cmd), .host_ba(host_ba), .host_addr(host_addr),
    .ram_cke(ram_cke), .ram_cmd_n(ram_cmd_n), .ram_ba(ram_ba), .ram_addr(ram_addr),
    .init_done(init_done), .ref_overrun(ref_overrun)
`ifdef LPDDR_SCHED_STATS_EN
    , .ref_count(ref_count), .host_stall_cyc(host_stall_cyc)
`endif
  );

  lpddr_cmd_sched #(
    .T_INIT_CYC(20), .T_REFI_CYC(3), .T_RP_CYC(2), .T_RFC_CYC(5), .T_MRD_CYC(2)
  ) dut_ovr (
    .clk(clk), .rst(rst),
    .host_valid(1'b0), .host_ready(ovr_ready),
    .host_cmd(4'b0111), .host_ba(2'b00), .host_addr(14'h0000),
    .ram_cke(ovr_cke), .ram_cmd_n(ovr_cmd_n), .ram_ba(ovr_ba), .ram_addr(ovr_addr),
    .init_done(ovr_init_done), .ref_overrun(ovr_overrun)
`ifdef LPDDR_SCHED_STATS_EN
    , .ref_count(ovr_ref_count), .host_stall_cyc(ovr_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] cmd,
                               input logic [1:0] ba, input logic [13:0] addr);
    host_valid = valid;
    host_cmd   = cmd;
    host_ba    = ba;
    host_addr  = addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) step();
  endtask

  // Starts right after reset release (cyc == 0) and ends at cyc 41 with init_done set.
  task automatic runInit(input string pass);
    int bad;
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (ram_cke !== 1'b0 || ram_cmd_n !== 4'b1111 || host_ready !== 1'b0) bad++;
    end
    checkOutput({pass, "_cke_low_window"}, bad, 0);
    step();
    checkOutput({pass, "_cke_rise"}, ram_cke, 1);
    checkOutput({pass, "_desel_at_rise"}, ram_cmd_n, 4'b1111);
    for (int i = 0; i < 21; i++) begin
      step();
      checkOutput($sformatf("%s_init_cmd%0d", pass, i), ram_cmd_n, initSeq[i]);
      if (i == 0)  checkOutput({pass, "_prea_a10"}, ram_addr[10], 1);
      if (i == 15) begin
        checkOutput({pass, "_mrs_addr"}, ram_addr, 14'h0032);
        checkOutput({pass, "_mrs_ba"}, ram_ba, 2'b00);
      end
      if (i == 18) begin
        checkOutput({pass, "_emrs_addr"}, ram_addr, 14'h0000);
        checkOutput({pass, "_emrs_ba"}, ram_ba, 2'b10);
      end
      if (i == 19) checkOutput({pass, "_init_done_low"}, init_done, 0);
      if (i == 20) begin
        checkOutput({pass, "_init_done_high"}, init_done, 1);
        checkOutput({pass, "_ready_after_init"}, host_ready, 1);
        checkOutput({pass, "_ovr_dut_clean"}, ovr_overrun, 0);
      end
    end
  endtask

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    cyc    = 0;
    initSeq[0] = 4'b0010;
    for (int i = 1; i < 21; i++) initSeq[i] = 4'b0111;
    initSeq[3]  = 4'b0001;
    initSeq[9]  = 4'b0001;
    initSeq[15] = 4'b0000;
    initSeq[18] = 4'b0000;

    rst = 1'b1;
    applyStimulus(1'b0, 4'b0111, 2'b00, 14'h0000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cke", ram_cke, 0);
    checkOutput("reset_cmd", ram_cmd_n, 4'b1111);
    checkOutput("reset_init_done", init_done, 0);
    checkOutput("reset_ready", host_ready, 0);
    checkOutput("reset_ba_addr", {ram_ba, ram_addr}, 0);
    checkOutput("reset_overrun", ref_overrun, 0);
    rst = 1'b0;
    cyc = 0;

    runInit("boot");

    // Idle refresh: expiry at cycle 81, PREA at 83, REF at 86, ready again at 91.
    waitUntil(80);
    checkOutput("ready_before_expiry", host_ready, 1);
    step();
    checkOutput("ready_drops_on_expiry", host_ready, 0);
    waitUntil(83);
    checkOutput("rt_prea_cmd", ram_cmd_n, 4'b0010);
    checkOutput("rt_prea_a10", ram_addr[10], 1);
    waitUntil(86);
    checkOutput("rt_ref_cmd", ram_cmd_n, 4'b0001);
    bad = 0;
    for (int k = 87; k <= 90; k++) begin
      step();
      if (ram_cmd_n !== 4'b0111 || host_ready !== 1'b0) bad++;
    end
    checkOutput("rt_rfc_nops_ready_low", bad, 0);
    step();
    checkOutput("rt_rfc_last_nop", ram_cmd_n, 4'b0111);
    checkOutput("ready_after_refresh", host_ready, 1);
    checkOutput("ovr_dut_overrun_set", ovr_overrun, 1);

    // Host traffic with latency one; illegal opcode becomes a NOP.
    applyStimulus(1'b1, 4'b0011, 2'd1, 14'h0123);
    step();
    checkOutput("act_cmd", ram_cmd_n, 4'b0011);
    checkOutput("act_ba", ram_ba, 2'd1);
    checkOutput("act_addr", ram_addr, 14'h0123);
    checkOutput("act_ready", host_ready, 1);
    applyStimulus(1'b1, 4'b0101, 2'd2, 14'h0456);
    step();
    checkOutput("rd_cmd", {ram_cmd_n, ram_ba, ram_addr}, {4'b0101, 2'd2, 14'h0456});
    applyStimulus(1'b1, 4'b0001, 2'd3, 14'h3FFF);
    step();
    checkOutput("illegal_as_nop", {ram_cmd_n, ram_ba, ram_addr}, {4'b0111, 2'd2, 14'h0456});
    applyStimulus(1'b1, 4'b0100, 2'd3, 14'h07FF);
    step();
    checkOutput("wr_cmd", {ram_cmd_n, ram_ba, ram_addr}, {4'b0100, 2'd3, 14'h07FF});
    applyStimulus(1'b0, 4'b0111, 2'd0, 14'h0000);
    step();
    checkOutput("idle_nop_holds", {ram_cmd_n, ram_ba, ram_addr}, {4'b0111, 2'd3, 14'h07FF});

    // Host command in the expiry cycle wins; refresh follows.
    waitUntil(120);
    checkOutput("ready_at_expiry_cycle", host_ready, 1);
    applyStimulus(1'b1, 4'b0011, 2'd2, 14'h00AB);
    step();
    applyStimulus(1'b0, 4'b0111, 2'd0, 14'h0000);
    checkOutput("race_host_cmd", {ram_cmd_n, ram_ba, ram_addr}, {4'b0011, 2'd2, 14'h00AB});
    checkOutput("race_ready_low", host_ready, 0);
    step();
    checkOutput("race_gap_nop", ram_cmd_n, 4'b0111);
    step();
    checkOutput("race_prea_cmd", ram_cmd_n, 4'b0010);
    checkOutput("race_prea_a10", ram_addr[10], 1);
    checkOutput("main_no_overrun", ref_overrun, 0);
    waitUntil(126);
    checkOutput("race_ref_cmd", ram_cmd_n, 4'b0001);

    // Reset pulse inside the post-refresh wait.
    step();
    rst = 1'b1;
    #1;
    checkOutput("midrst_cke", ram_cke, 0);
    checkOutput("midrst_cmd", ram_cmd_n, 4'b1111);
    checkOutput("midrst_init_done", init_done, 0);
    checkOutput("midrst_ready", host_ready, 0);
    checkOutput("midrst_ba_addr", {ram_ba, ram_addr}, 0);
    checkOutput("midrst_ovr_clear", ovr_overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    runInit("replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
